// File: rtl/systolic_ws_controller_pkg.sv
// Shared types and constants for the weight-stationary array sequencer:
// FSM state encoding and the array's 2-bit control bus values.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] SA_CTRL_HOLD = 2'b00;
    localparam logic [1:0] SA_CTRL_LOAD = 2'b01;
    localparam logic [1:0] SA_CTRL_COMP = 2'b10;

endpackage

// File: rtl/systolic_ws_controller_if.sv
// Front-end streams into the sequencer: weight rows and activation vectors,
// each a valid/ready handshake. master = tile/DMA side, slave = sequencer.
interface systolic_ws_controller_if #(
    parameter int ARR_WIDTH  = 8,
    parameter int ARR_HEIGHT = 8,
    parameter int WORD_WIDTH = 8
);
    logic                             w_valid;
    logic                             w_ready;
    logic [WORD_WIDTH*ARR_WIDTH-1:0]  w_row;
    logic                             a_valid;
    logic                             a_ready;
    logic [WORD_WIDTH*ARR_HEIGHT-1:0] a_vec;

    modport master (
        output w_valid, w_row, a_valid, a_vec,
        input  w_ready, a_ready
    );

    modport slave (
        input  w_valid, w_row, a_valid, a_vec,
        output w_ready, a_ready
    );
endinterface

// File: rtl/systolic_ws_controller_skew_buffer.sv
// Triangular delay line. Lane i is delayed i cycles (REVERSE=0) or
// LANES-1-i cycles (REVERSE=1); a zero-depth lane is a straight wire.
module sa_skew_buffer #(
    parameter int LANES   = 8,
    parameter int LANE_W  = 8,
    parameter bit REVERSE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [LANES*LANE_W-1:0] din,
    output logic [LANES*LANE_W-1:0] dout
);
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int DEPTH = REVERSE ? (LANES - 1 - i) : i;
        if (DEPTH == 0) begin : g_direct
            assign dout[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
        end else begin : g_delay
            logic [LANE_W-1:0] dly_p [DEPTH];
            // Shift this lane's word one stage per cycle.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < DEPTH; k++) dly_p[k] <= '0;
                end else begin
                    dly_p[0] <= din[i*LANE_W +: LANE_W];
                    for (int k = 1; k < DEPTH; k++) dly_p[k] <= dly_p[k-1];
                end
            end
            assign dout[i*LANE_W +: LANE_W] = dly_p[DEPTH-1];
        end
    end
endmodule

// File: rtl/systolic_ws_controller.sv
// Sequencer for a weight-stationary systolic array: loads one weight tile,
// streams activation vectors (skewed) and returns de-skewed partial-sum rows.
// Optional macro SA_CTRL_PERF_EN adds busy/stall performance counters.
module systolic_ws_controller
    import sa_ctrl_pkg::*;
#(
    parameter int ARR_WIDTH  = 8,
    parameter int ARR_HEIGHT = 8,
    parameter int WORD_WIDTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  num_vecs,
    output logic                              busy,
    output logic                              done,
    systolic_ws_controller_if.slave           fe,
    output logic [1:0]                        sa_control,
    output logic [WORD_WIDTH*ARR_WIDTH-1:0]   sa_w_in_vec,
    output logic [WORD_WIDTH*ARR_HEIGHT-1:0]  sa_a_in_vec,
    input  logic [4*WORD_WIDTH*ARR_WIDTH-1:0] sa_ps_out_vec,
    output logic                              out_valid,
    output logic [4*WORD_WIDTH*ARR_WIDTH-1:0] out_vec
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]                       perf_busy_cycles,
    output logic [31:0]                       perf_stall_cycles
`endif
);
    localparam int PS_W   = 4 * WORD_WIDTH;
    localparam int LAT    = ARR_HEIGHT + ARR_WIDTH;
    localparam int WCNT_W = $clog2(ARR_HEIGHT + 1);
    localparam int DCNT_W = $clog2(LAT);

    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                num_vecs_q;
    logic [CNT_W-1:0]                a_cnt;
    logic [WCNT_W-1:0]               w_cnt;
    logic [DCNT_W-1:0]               drain_cnt;
    logic                            start_acc;
    logic                            w_hs;
    logic                            a_hs;
    logic                            a_room;
    logic [LAT-1:0]                  vld_pipe;
    logic [WORD_WIDTH*ARR_HEIGHT-1:0] a_skew_in;
    logic [PS_W*ARR_WIDTH-1:0]       ps_aligned;

    assign start_acc = (state == ST_IDLE) && start;
    assign a_room    = (a_cnt < num_vecs_q);

    // Next-state and all control outputs decoded from the current state.
    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        fe.w_ready  = 1'b0;
        fe.a_ready  = 1'b0;
        sa_control  = SA_CTRL_HOLD;
        sa_w_in_vec = '0;
        w_hs        = 1'b0;
        a_hs        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                busy       = 1'b1;
                fe.w_ready = 1'b1;
                w_hs       = fe.w_valid;
                if (w_hs) begin
                    sa_control  = SA_CTRL_LOAD;
                    sa_w_in_vec = fe.w_row;
                    if (w_cnt == WCNT_W'(ARR_HEIGHT - 1))
                        state_nxt = (num_vecs_q == '0) ? ST_DONE : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                busy       = 1'b1;
                sa_control = SA_CTRL_COMP;
                fe.a_ready = a_room;
                a_hs       = fe.a_valid && a_room;
                if (a_hs && (a_cnt == num_vecs_q - 1'b1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The last accept cycle counts as the first of LAT flush
                // cycles, so done lines up with the final out_valid.
                busy       = 1'b1;
                sa_control = SA_CTRL_COMP;
                if (drain_cnt == DCNT_W'(LAT - 2)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Job length latch and row/vector/drain counters, cleared on accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_vecs_q <= '0;
            a_cnt      <= '0;
            w_cnt      <= '0;
            drain_cnt  <= '0;
        end else if (start_acc) begin
            num_vecs_q <= num_vecs;
            a_cnt      <= '0;
            w_cnt      <= '0;
            drain_cnt  <= '0;
        end else begin
            if (w_hs)               w_cnt     <= w_cnt + 1'b1;
            if (a_hs)               a_cnt     <= a_cnt + 1'b1;
            if (state == ST_DRAIN)  drain_cnt <= drain_cnt + 1'b1;
        end
    end

    // ---- input skew: zero bubble whenever no vector is accepted ----
    assign a_skew_in = a_hs ? fe.a_vec : '0;

    sa_skew_buffer #(
        .LANES   (ARR_HEIGHT),
        .LANE_W  (WORD_WIDTH),
        .REVERSE (1'b0)
    ) u_in_skew (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (a_skew_in),
        .dout    (sa_a_in_vec)
    );

    // ---- output de-skew: column c waits ARR_WIDTH-1-c cycles ----
    sa_skew_buffer #(
        .LANES   (ARR_WIDTH),
        .LANE_W  (PS_W),
        .REVERSE (1'b1)
    ) u_out_deskew (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sa_ps_out_vec),
        .dout    (ps_aligned)
    );

    // Valid pipe tracks each accepted vector; the final stage is out_valid and
    // the row register loads alongside it, holding between results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            out_vec  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-2:0], a_hs};
            if (vld_pipe[LAT-2]) out_vec <= ps_aligned;
        end
    end

    assign out_valid = vld_pipe[LAT-1];

`ifdef SA_CTRL_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Busy and handshake-stall cycle counters, saturating, cleared per job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (start_acc) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy) perf_busy_cycles <= sat_inc(perf_busy_cycles);
            if ((state == ST_LOAD_W && !w_hs) || (state == ST_COMPUTE && !a_hs))
                perf_stall_cycles <= sat_inc(perf_stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ws_controller.sv
// Directed bench for systolic_ws_controller with a behavioural 8x8
// weight-stationary array attached to the sa_* ports.
module tb_systolic_ws_controller;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [15:0]  num_vecs;
    logic         busy;
    logic         done;
    logic [1:0]   sa_control;
    logic [63:0]  sa_w_in_vec;
    logic [63:0]  sa_a_in_vec;
    logic [255:0] sa_ps_out_vec;
    logic         out_valid;
    logic [255:0] out_vec;
`ifdef SA_CTRL_PERF_EN
    logic [31:0]  perf_busy_cycles;
    logic [31:0]  perf_stall_cycles;
`endif

    systolic_ws_controller_if fe ();

    systolic_ws_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .num_vecs      (num_vecs),
        .busy          (busy),
        .done          (done),
        .fe            (fe),
        .sa_control    (sa_control),
        .sa_w_in_vec   (sa_w_in_vec),
        .sa_a_in_vec   (sa_a_in_vec),
        .sa_ps_out_vec (sa_ps_out_vec),
        .out_valid     (out_valid),
        .out_vec       (out_vec)
`ifdef SA_CTRL_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural array: weights shift down on 01, PEs compute on 10.
    logic [7:0]  wt  [8][8];
    logic [7:0]  act [8][8];
    logic [31:0] ps  [8][8];

    function automatic logic [7:0] pe_a(input int r, input int c);
        if (c == 0) return sa_a_in_vec[r*8 +: 8];
        return act[r][c-1];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    wt[r][c]  <= 8'd0;
                    act[r][c] <= 8'd0;
                    ps[r][c]  <= 32'd0;
                end
        end else if (sa_control == 2'b01) begin
            for (int c = 0; c < 8; c++) begin
                wt[0][c] <= sa_w_in_vec[c*8 +: 8];
                for (int r = 1; r < 8; r++) wt[r][c] <= wt[r-1][c];
            end
        end else if (sa_control == 2'b10) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    act[r][c] <= pe_a(r, c);
                    ps[r][c]  <= ((r == 0) ? 32'd0 : ps[r-1][c]) + 32'(pe_a(r, c)) * 32'(wt[r][c]);
                end
        end
    end

    always_comb begin
        sa_ps_out_vec = '0;
        for (int c = 0; c < 8; c++) sa_ps_out_vec[c*32 +: 32] = ps[7][c];
    end

    // Monitor: event timestamps sampled on the falling edge.
    int           acc_q[$];
    int           out_cyc_q[$];
    logic [255:0] out_row_q[$];
    int           done_cnt   = 0;
    int           done_cyc   = 0;
    int           shift_cnt  = 0;
    int           hold_cnt   = 0;
    int           first_shift = 0;
    int           last_shift = 0;
    int           first_comp = 0;
    int           busy_rise  = 0;
    logic [1:0]   prev_ctrl  = 2'b00;
    logic         prev_busy  = 1'b0;

    always @(negedge clk) begin
        if (fe.a_valid && fe.a_ready) acc_q.push_back(cyc);
        if (out_valid) begin
            out_cyc_q.push_back(cyc);
            out_row_q.push_back(out_vec);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (sa_control == 2'b01) begin
            if (prev_ctrl != 2'b01) first_shift <= cyc;
            last_shift <= cyc;
            shift_cnt  <= shift_cnt + 1;
        end
        if (sa_control == 2'b10 && prev_ctrl != 2'b10) first_comp <= cyc;
        if (busy && sa_control == 2'b00) hold_cnt <= hold_cnt + 1;
        if (busy && !prev_busy) busy_rise <= cyc;
        prev_ctrl <= sa_control;
        prev_busy <= busy;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_vec(input int base);
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < 8; r++) v[r*8 +: 8] = 8'(base + r);
        return v;
    endfunction

    // Identity weights: column c = a[c]. All-ones weights: every column = sum of a.
    function automatic logic [255:0] exp_row(input int base, input bit ones);
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[c*32 +: 32] = ones ? 32'(8*base + 28) : 32'(base + c);
        return v;
    endfunction

    task automatic pulse_start(input logic [15:0] nv, output int s);
        start    = 1'b1;
        num_vecs = nv;
        s        = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] row);
        int n;
        n = 0;
        fe.w_valid = 1'b1;
        fe.w_row   = row;
        @(negedge clk);
        while (!fe.w_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w_accept", 256'(fe.w_ready), 256'(1));
        @(posedge clk); #1;
    endtask

    task automatic send_a(input logic [63:0] vec);
        int n;
        n = 0;
        fe.a_valid = 1'b1;
        fe.a_vec   = vec;
        @(negedge clk);
        while (!fe.a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept", 256'(fe.a_ready), 256'(1));
        @(posedge clk); #1;
    endtask

    // Sends 8 rows; the k-th row ends in array row 7-k. stall_at inserts a
    // 2-cycle w_valid gap before that row (-1: none).
    task automatic load_weights(input bit ones, input int stall_at);
        for (int k = 0; k < 8; k++) begin
            if (k == stall_at) begin
                fe.w_valid = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
            end
            send_w(ones ? 64'h0101010101010101 : (64'h1 << ((7 - k) * 8)));
        end
        fe.w_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_pulse", 256'(done), 256'(1));
        @(posedge clk); #1;
    endtask

    task automatic check_results(input int ob, input int ab, input int n,
                                 input int b0, input int b1, input int b2, input bit ones);
        int bases[3];
        bases = '{b0, b1, b2};
        chk("out_count", 256'(out_cyc_q.size() - ob), 256'(n));
        for (int i = 0; i < n; i++) begin
            chk("out_cycle", 256'(out_cyc_q[ob+i]), 256'(acc_q[ab+i] + 16));
            chk("out_row", out_row_q[ob+i], exp_row(bases[i], ones));
        end
        chk("done_cycle", 256'(done_cyc), 256'(acc_q[ab+n-1] + 16));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, ob, ab, sc, hc, dc;
        reset_n    = 1'b0;
        start      = 1'b0;
        num_vecs   = '0;
        fe.w_valid = 1'b0;
        fe.w_row   = '0;
        fe.a_valid = 1'b0;
        fe.a_vec   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_w_ready", 256'(fe.w_ready), 256'(0));
        chk("rst_a_ready", 256'(fe.a_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_sa_control", 256'(sa_control), 256'(0));
        chk("rst_out_vec", out_vec, 256'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Job 1: identity weights, 3 back-to-back vectors
        ob = out_cyc_q.size(); ab = acc_q.size(); sc = shift_cnt; hc = hold_cnt;
        pulse_start(16'd3, s);
        load_weights(1'b0, -1);
        send_a(mk_vec(1));
        send_a(mk_vec(9));
        send_a(mk_vec(17));
        fe.a_valid = 1'b0;
        wait_done();
        chk("j1_busy_rise", 256'(busy_rise), 256'(s + 1));
        chk("j1_shift_count", 256'(shift_cnt - sc), 256'(8));
        chk("j1_first_shift", 256'(first_shift), 256'(s + 1));
        chk("j1_last_shift", 256'(last_shift), 256'(s + 8));
        chk("j1_first_comp", 256'(first_comp), 256'(s + 9));
        chk("j1_load_holds", 256'(hold_cnt - hc), 256'(0));
        chk("j1_first_accept", 256'(acc_q[ab]), 256'(s + 9));
        check_results(ob, ab, 3, 1, 9, 17, 1'b0);
        @(negedge clk);
        chk("j1_idle_valid", 256'(out_valid), 256'(0));
        chk("j1_out_hold", out_vec, exp_row(17, 1'b0));
        @(posedge clk); #1;

        // Job 2: all-ones weights with a load stall, 2-cycle activation bubble
        ob = out_cyc_q.size(); ab = acc_q.size(); sc = shift_cnt; hc = hold_cnt;
        pulse_start(16'd2, s);
        load_weights(1'b1, 3);
        send_a(mk_vec(1));
        fe.a_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        send_a(mk_vec(9));
        fe.a_valid = 1'b0;
        wait_done();
        chk("j2_shift_count", 256'(shift_cnt - sc), 256'(8));
        chk("j2_stall_holds", 256'(hold_cnt - hc), 256'(2));
        chk("j2_first_comp", 256'(first_comp), 256'(last_shift + 1));
        check_results(ob, ab, 2, 1, 9, 0, 1'b1);
        chk("j2_out_gap", 256'(out_cyc_q[ob+1] - out_cyc_q[ob]), 256'(3));

        // Job 3: num_vecs=0, and a start during DONE is ignored
        ob = out_cyc_q.size(); dc = done_cnt;
        pulse_start(16'd0, s);
        load_weights(1'b0, -1);
        start    = 1'b1;
        num_vecs = 16'd5;
        @(negedge clk);
        chk("j3_done_after_load", 256'(done), 256'(1));
        chk("j3_busy_in_done", 256'(busy), 256'(0));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("j3_start_ignored", 256'(busy), 256'(0));
        chk("j3_idle_w_ready", 256'(fe.w_ready), 256'(0));
        repeat (20) @(posedge clk);
        #1;
        chk("j3_no_outputs", 256'(out_cyc_q.size() - ob), 256'(0));
        chk("j3_one_done", 256'(done_cnt - dc), 256'(1));

        // Job 4: reset mid-COMPUTE, then a clean job
        ob = out_cyc_q.size();
        pulse_start(16'd3, s);
        load_weights(1'b0, -1);
        send_a(mk_vec(1));
        fe.a_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_busy", 256'(busy), 256'(0));
        chk("ar_sa_control", 256'(sa_control), 256'(0));
        chk("ar_sa_a_in", 256'(sa_a_in_vec), 256'(0));
        chk("ar_sa_w_in", 256'(sa_w_in_vec), 256'(0));
        chk("ar_a_ready", 256'(fe.a_ready), 256'(0));
        chk("ar_out_valid", 256'(out_valid), 256'(0));
        chk("ar_out_vec", out_vec, 256'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        ab = acc_q.size();
        pulse_start(16'd2, s);
        load_weights(1'b0, -1);
        send_a(mk_vec(17));
        send_a(mk_vec(1));
        fe.a_valid = 1'b0;
        wait_done();
        check_results(ob, ab, 2, 17, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_ws_controller.md
Name: systolic_ws_controller

Overview:
- Sequencer for the 8x8 weight-stationary systolic array: preloads one weight tile, then streams activation vectors through it and returns aligned partial-sum rows.
- Owns the array's 2-bit control bus and input ports; applies input skew to activations and de-skew to array outputs.
- Sits between the tile/DMA front end (valid/ready streams) and the array instance.

Parameters:
- ARR_WIDTH, 8, array columns (weight row width, output columns)
- ARR_HEIGHT, 8, array rows (activation vector length, weight rows per tile)
- WORD_WIDTH, 8, activation/weight word width; partial sums are 4*WORD_WIDTH
- CNT_W, 16, width of the vector counter and num_vecs

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a job when idle
- num_vecs  in  CNT_W  activation vectors in the job; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- w_valid / w_ready  in / out  1  weight-row stream handshake
- w_row  in  WORD_WIDTH*ARR_WIDTH  one weight row
- a_valid / a_ready  in / out  1  activation stream handshake
- a_vec  in  WORD_WIDTH*ARR_HEIGHT  one activation vector
- sa_control  out  2  array control: 00 hold, 01 weight shift, 10 compute
- sa_w_in_vec  out  WORD_WIDTH*ARR_WIDTH  to array weight input
- sa_a_in_vec  out  WORD_WIDTH*ARR_HEIGHT  to array activation input (skewed)
- sa_ps_out_vec  in  4*WORD_WIDTH*ARR_WIDTH  from array partial-sum output
- out_valid  out  1  aligned result row valid (no backpressure)
- out_vec  out  4*WORD_WIDTH*ARR_WIDTH  de-skewed partial-sum row

Behaviour:
- Reset (async, immediate): state IDLE, counters 0, skew/de-skew registers and valid pipe 0. busy, done, w_ready, a_ready, out_valid, sa_control, sa_w_in_vec, sa_a_in_vec and out_vec are all 0.
- FSM states: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE: start=1 latches num_vecs, clears counters and enters LOAD_W. start in any other state is ignored.
- LOAD_W:
  - w_ready=1.
  - On each w_valid&w_ready: sa_control=01 and sa_w_in_vec=w_row in that cycle; otherwise sa_control=00 (hold) and sa_w_in_vec=0.
  - The first accepted row ends in array row ARR_HEIGHT-1.
  - After ARR_HEIGHT accepted rows, go to COMPUTE, or to DONE if num_vecs==0.
- COMPUTE:
  - sa_control=10; a_ready=1 while accepted count < num_vecs.
  - Handshake cycle: the vector enters the skew buffer and a valid bit enters the valid pipe.
  - Cycle with no handshake: a zero bubble enters the skew buffer with valid bit 0, and sa_control stays 10.
  - After the num_vecs-th accept, go to DRAIN.
- DRAIN: sa_control=10, zeros fed. Runs a counter of ARR_HEIGHT+ARR_WIDTH cycles, then goes to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE. A start in this cycle is ignored.
- Input skew: activation element r is delayed r cycles (row 0 direct).
- Output de-skew: column c of sa_ps_out_vec is delayed ARR_WIDTH-1-c cycles.
- Latency: a vector accepted at cycle t gives out_valid=1 with its row at cycle t+ARR_HEIGHT+ARR_WIDTH. The valid pipe has exactly this depth.
- out_vec holds its last value when out_valid=0.
- Widths: partial sums pass through unmodified (4*WORD_WIDTH); no arithmetic in the block.
- Counters never wrap: num_vecs is at most 2^CNT_W-1.

Optional Feature:
- Macro SA_CTRL_PERF_EN.
- Defined: adds outputs perf_busy_cycles and perf_stall_cycles (32 bits each). They count busy cycles and LOAD_W/COMPUTE cycles without a handshake. They clear on accepted start, saturate at all-ones, and reset to 0.
- Undefined: ports and logic absent.

Decomposition:
- Package sa_ctrl_pkg: state enum; control encodings SA_CTRL_HOLD=2'b00, SA_CTRL_LOAD=2'b01, SA_CTRL_COMP=2'b10.
- Sub-module sa_skew_buffer: triangular delay line with parameters LANES, LANE_W and REVERSE. Lane i delays i cycles, or LANES-1-i when REVERSE=1. Instantiated twice: input skew and output de-skew.

Test Plan:
- Weight load with 8 rows, w_valid held high: sa_control=01 for exactly 8 consecutive cycles, then 10; busy=1 from the cycle after start.
- Weight stall, w_valid low on cycles 3-4: sa_control=00 on those cycles, and still exactly 8 shift cycles total.
- Identity weights, num_vecs=3, a_vec = 1..8, 9..16, 17..24, a_valid always high: out_valid at t0+16, t0+17, t0+18 with matching sums; done 16 cycles after the last accept.
- Activation bubble, a_valid low for 2 cycles between vectors: out_valid shows a 2-cycle gap and results are unchanged.
- num_vecs=0: load 8 rows, then done with no out_valid.
- reset_n low mid-COMPUTE: all outputs 0 immediately; a new start after release runs a clean job.
